ascii_time_entry: RTL and testbench

Converts a stream of ASCII characters (from the UART receive path or the keypad scanner) into a validated 24-hour HH:MM:SS BCD time. It is the inverse of the BCD-to-ASCII LCD character path.
- Digits are collected into an edit buffer.
- Backspace and cancel are supported.
- The buffer commits to the output registers on Enter, only after all six digits are entered and in range.
- The clock/alarm setting logic consumes the committed value on a one-cycle strobe.

---
 rtl/ascii_time_entry.sv | 133 +++++++++++++
 tb/tb_ascii_time_entry.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ascii_time_entry.sv
// ASCII character stream to validated 24-hour HH:MM:SS BCD time entry.
// Digits fill an edit buffer; Enter commits a full, range-checked buffer.
module ascii_time_entry #(
  parameter logic [7:0] ENTER_CHAR  = 8'h0D,
  parameter logic [7:0] BKSP_CHAR   = 8'h08,
  parameter logic [7:0] CANCEL_CHAR = 8'h1B
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_ascii_data,
  input  logic        i_ascii_valid,
  output logic [23:0] o_edit_bcd,
  output logic [2:0]  o_cursor,
  output logic [23:0] o_time_bcd,
  output logic        o_set_pulse,
  output logic        o_err
);

  typedef enum logic [1:0] {StEmpty, StEntry, StFull} state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [5:0][3:0]  r_dig;
  logic [5:0][3:0]  w_dig_d;
  logic [2:0]       r_cursor;
  logic [2:0]       w_cursor_d;
  logic [23:0]      r_time;
  logic [23:0]      w_time_d;
  logic             r_commit;
  logic             w_commit_d;
  logic             r_set_pulse;
  logic             r_err;
  logic             w_err_d;

  logic             w_is_digit;
  logic             w_is_ignore;
  logic [3:0]       w_digit;
  logic             w_in_range;

  assign w_digit     = i_ascii_data[3:0];
  assign w_is_digit  = (i_ascii_data >= 8'h30) && (i_ascii_data <= 8'h39);
  assign w_is_ignore = (i_ascii_data == 8'h3A) || (i_ascii_data == 8'h20);

  // Per-position limit; digit element 5 holds the hours tens.
  always_comb begin
    w_in_range = 1'b0;
    case (r_cursor)
      3'd0:    w_in_range = (w_digit <= 4'd2);
      3'd1:    w_in_range = (r_dig[5] == 4'd2) ? (w_digit <= 4'd3) : 1'b1;
      3'd2:    w_in_range = (w_digit <= 4'd5);
      3'd3:    w_in_range = 1'b1;
      3'd4:    w_in_range = (w_digit <= 4'd5);
      3'd5:    w_in_range = 1'b1;
      default: w_in_range = 1'b0;
    endcase
  end

  // State register together with the buffered datapath.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StEmpty;
      r_dig       <= '0;
      r_cursor    <= 3'd0;
      r_time      <= 24'h000000;
      r_commit    <= 1'b0;
      r_set_pulse <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_dig       <= w_dig_d;
      r_cursor    <= w_cursor_d;
      r_time      <= w_time_d;
      r_commit    <= w_commit_d;
      r_set_pulse <= r_commit;
      r_err       <= w_err_d;
    end
  end

  // Next-state and datapath decode of one incoming character.
  always_comb begin
    w_dig_d    = r_dig;
    w_cursor_d = r_cursor;
    w_time_d   = r_time;
    w_commit_d = 1'b0;
    w_err_d    = 1'b0;
    if (i_ascii_valid) begin
      if (w_is_digit) begin
        if (r_state == StFull || !w_in_range) begin
          w_err_d = 1'b1;
        end else begin
          w_dig_d[3'd5 - r_cursor] = w_digit;
          w_cursor_d               = r_cursor + 3'd1;
        end
      end else if (i_ascii_data == ENTER_CHAR) begin
        if (r_state == StFull) begin
          w_time_d   = r_dig;
          w_dig_d    = '0;
          w_cursor_d = 3'd0;
          w_commit_d = 1'b1;
        end else begin
          w_err_d = 1'b1;
        end
      end else if (i_ascii_data == BKSP_CHAR) begin
        if (r_cursor != 3'd0) begin
          w_dig_d[3'd6 - r_cursor] = 4'd0;
          w_cursor_d               = r_cursor - 3'd1;
        end
      end else if (i_ascii_data == CANCEL_CHAR) begin
        w_dig_d    = '0;
        w_cursor_d = 3'd0;
      end else if (!w_is_ignore) begin
        w_err_d = 1'b1;
      end
    end

    if (w_cursor_d == 3'd0) begin
      w_state_d = StEmpty;
    end else if (w_cursor_d == 3'd6) begin
      w_state_d = StFull;
    end else begin
      w_state_d = StEntry;
    end
  end

  always_comb begin
    o_edit_bcd  = r_dig;
    o_cursor    = r_cursor;
    o_time_bcd  = r_time;
    o_set_pulse = r_set_pulse;
    o_err       = r_err;
  end

endmodule

// File: tb/tb_ascii_time_entry.sv
// Directed self-checking bench for ascii_time_entry.
module tb_ascii_time_entry;

  logic        clk;
  logic        rst;
  logic [7:0]  ascii_data;
  logic        ascii_valid;
  logic [23:0] edit_bcd;
  logic [2:0]  cursor;
  logic [23:0] time_bcd;
  logic        set_pulse;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  ascii_time_entry dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_ascii_data  (ascii_data),
    .i_ascii_valid (ascii_valid),
    .o_edit_bcd    (edit_bcd),
    .o_cursor      (cursor),
    .o_time_bcd    (time_bcd),
    .o_set_pulse   (set_pulse),
    .o_err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one character for exactly one edge, returns 1ns after it.
  task automatic send(input logic [7:0] ch);
    @(negedge clk);
    ascii_data  = ch;
    ascii_valid = 1'b1;
    @(posedge clk);
    #1;
    ascii_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  initial begin
    rst         = 1'b1;
    ascii_data  = 8'h00;
    ascii_valid = 1'b0;
    tick();
    tick();
    check("rst_edit", 32'(edit_bcd), 32'h0);
    check("rst_cursor", 32'(cursor), 32'h0);
    check("rst_time", 32'(time_bcd), 32'h0);
    check("rst_set", 32'(set_pulse), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rst = 1'b0;

    // Plain entry and commit.
    send("1"); check("t1_cur1", 32'(cursor), 32'd1); check("t1_err1", 32'(err), 32'h0);
    send("2"); check("t1_cur2", 32'(cursor), 32'd2);
    send("3"); check("t1_cur3", 32'(cursor), 32'd3);
    send("4"); check("t1_cur4", 32'(cursor), 32'd4);
    send("5"); check("t1_cur5", 32'(cursor), 32'd5);
    send("6"); check("t1_cur6", 32'(cursor), 32'd6); check("t1_err6", 32'(err), 32'h0);
    check("t1_edit", 32'(edit_bcd), 32'h123456);
    send(8'h0D);
    check("t1_time", 32'(time_bcd), 32'h123456);
    check("t1_cur0", 32'(cursor), 32'd0);
    check("t1_edit0", 32'(edit_bcd), 32'h0);
    check("t1_set_early", 32'(set_pulse), 32'h0);
    check("t1_err_ent", 32'(err), 32'h0);
    tick();
    check("t1_set_hi", 32'(set_pulse), 32'h1);
    check("t1_err_set", 32'(err), 32'h0);
    tick();
    check("t1_set_lo", 32'(set_pulse), 32'h0);

    // Hours-units limit when hours-tens is 2.
    send("2"); check("t2_cur1", 32'(cursor), 32'd1);
    send("4"); check("t2_err4", 32'(err), 32'h1); check("t2_cur_hold", 32'(cursor), 32'd1);
    check("t2_edit_hold", 32'(edit_bcd), 32'h200000);
    send("3"); check("t2_err_clr", 32'(err), 32'h0); check("t2_cur2", 32'(cursor), 32'd2);
    send_str("5959");
    send(8'h0D);
    check("t2_time", 32'(time_bcd), 32'h235959);
    tick();
    tick();

    // Ignorable colon and backspace.
    send_str("12");
    send(":"); check("t3_colon_err", 32'(err), 32'h0); check("t3_colon_cur", 32'(cursor), 32'd2);
    send("3"); check("t3_cur3", 32'(cursor), 32'd3);
    send(8'h08); check("t3_bk_cur", 32'(cursor), 32'd2); check("t3_bk_edit", 32'(edit_bcd), 32'h120000);
    check("t3_bk_err", 32'(err), 32'h0);
    send_str("4000");
    check("t3_edit", 32'(edit_bcd), 32'h124000);
    send(8'h0D);
    check("t3_time", 32'(time_bcd), 32'h124000);
    tick();
    tick();

    // Early Enter, then cancel.
    send_str("123");
    send(8'h0D);
    check("t4_err", 32'(err), 32'h1);
    check("t4_cur", 32'(cursor), 32'd3);
    check("t4_time", 32'(time_bcd), 32'h124000);
    send(8'h1B);
    check("t4_esc_cur", 32'(cursor), 32'd0);
    check("t4_esc_edit", 32'(edit_bcd), 32'h0);
    check("t4_esc_err", 32'(err), 32'h0);
    send(8'h08); check("t4_bk0_err", 32'(err), 32'h0); check("t4_bk0_cur", 32'(cursor), 32'd0);
    send("3"); check("t4_ht_range", 32'(err), 32'h1); check("t4_ht_cur", 32'(cursor), 32'd0);

    // Overflow digit and illegal character in FULL.
    send_str("153045");
    send("7"); check("t5_err7", 32'(err), 32'h1); check("t5_cur6", 32'(cursor), 32'd6);
    send("A"); check("t5_errA", 32'(err), 32'h1);
    check("t5_edit", 32'(edit_bcd), 32'h153045);
    send(8'h0D);
    check("t5_time", 32'(time_bcd), 32'h153045);
    check("t5_err_ent", 32'(err), 32'h0);
    tick();
    tick();

    // Reset during the SET_PULSE cycle.
    send_str("010203");
    send(8'h0D);
    check("t6_time", 32'(time_bcd), 32'h010203);
    tick();
    check("t6_set_hi", 32'(set_pulse), 32'h1);
    rst = 1'b1;
    tick();
    check("t6_rst_time", 32'(time_bcd), 32'h0);
    check("t6_rst_set", 32'(set_pulse), 32'h0);
    check("t6_rst_cur", 32'(cursor), 32'd0);
    check("t6_rst_edit", 32'(edit_bcd), 32'h0);
    rst = 1'b0;

    // Digit on the cycle right after a commit.
    send_str("095959");
    @(negedge clk);
    ascii_data  = 8'h0D;
    ascii_valid = 1'b1;
    @(posedge clk);
    #1;
    ascii_data = "1";
    check("t7_time", 32'(time_bcd), 32'h095959);
    check("t7_cur0", 32'(cursor), 32'd0);
    @(posedge clk);
    #1;
    ascii_valid = 1'b0;
    check("t7_cur1", 32'(cursor), 32'd1);
    check("t7_edit", 32'(edit_bcd), 32'h100000);
    check("t7_set", 32'(set_pulse), 32'h1);
    check("t7_err", 32'(err), 32'h0);
    tick();
    check("t7_set_lo", 32'(set_pulse), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
